ecc2d_decoder: RTL

//  Receive side of the 2D SECDED path: consumes 32-bit codewords from the 2D encoder (after storage or link).

---
 rtl/ecc2d_pkg.sv | 42 ++++
 rtl/ecc2d_syndrome.sv | 25 ++
 rtl/ecc2d_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ecc2d_pkg.sv
// Shared constants, error classes and data-bit signature helper for the 2D SECDED decoder.
package ecc2d_pkg;

    localparam int unsigned CW_W   = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CHK_W  = 16;
    localparam int unsigned POS_W  = 5;

    // Check bits are packed per group slot g as {D(g+1), P(g+1), C_g[1:0]}
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned C_OFF  = 0;
    localparam int unsigned P_OFF  = 2;
    localparam int unsigned D_OFF  = 3;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        CORR_DATA = 2'd1,
        CORR_CHK  = 2'd2,
        UNCORR    = 2'd3
    } err_class_t;

    // 3-hot syndrome produced by a single flip of data bit k
    function automatic logic [CHK_W-1:0] sig(input logic [3:0] k);
        logic [1:0]       g;
        logic [1:0]       im1;
        logic             i_even;
        logic             dsel;
        logic [1:0]       dn;
        logic [CHK_W-1:0] s;
        g      = k[3:2];
        im1    = 2'd3 - k[1:0];
        i_even = im1[0];
        dsel   = g[0] ^ i_even;
        dn     = {g[1], dsel};
        s      = '0;
        s[4'(GRP_W * 32'(im1) + P_OFF)]                    = 1'b1;
        s[4'(GRP_W * 32'(g) + C_OFF + (i_even ? 0 : 1))]   = 1'b1;
        s[4'(GRP_W * 32'(dn) + D_OFF)]                     = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/ecc2d_syndrome.sv
// Combinational check-bit recompute and syndrome for one 32-bit 2D SECDED codeword.
module ecc2d_syndrome
    import ecc2d_pkg::*;
(
    input  logic [CW_W-1:0]  cw_i,
    output logic [CHK_W-1:0] syn_o
);

    logic [3:0]       a, b, c, d, p;
    logic [CHK_W-1:0] chk;

    // bit 3 of each group nibble is index 1, bit 0 is index 4
    assign {d, c, b, a} = cw_i[DATA_W-1:0];
    assign p = a ^ b ^ c ^ d;

    assign chk = {
        d[3] ^ c[2] ^ d[1] ^ c[0], p[0], d[3] ^ d[1], d[2] ^ d[0],
        c[3] ^ d[2] ^ c[1] ^ d[0], p[1], c[3] ^ c[1], c[2] ^ c[0],
        b[3] ^ a[2] ^ b[1] ^ a[0], p[2], b[3] ^ b[1], b[2] ^ b[0],
        a[3] ^ b[2] ^ a[1] ^ b[0], p[3], a[3] ^ a[1], a[2] ^ a[0]
    };

    assign syn_o = chk ^ cw_i[CW_W-1:DATA_W];

endmodule

// File: rtl/ecc2d_decoder.sv
// Two-stage 2D SECDED decoder: single-bit correction, multi-bit detection, optional stats.
// Error counters and cnt_* ports exist only when ECC_DEC_STATS_EN is defined.
module ecc2d_decoder
    import ecc2d_pkg::*;
`ifdef ECC_DEC_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic [POS_W-1:0]  out_err_pos
`ifdef ECC_DEC_STATS_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
`endif
);

    logic [CHK_W-1:0]  syn;
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [CHK_W-1:0]  s1_syn_q;
    logic              s2_adv;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_corr_q,  out_corr_d;
    logic              out_uncorr_q, out_uncorr_d;
    logic [POS_W-1:0]  out_pos_q,   out_pos_d;
    err_class_t        cls_d;
    logic              sig_hit;

    ecc2d_syndrome u_syndrome (
        .cw_i  (in_cw),
        .syn_o (syn)
    );

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // Stage 1: capture data and syndrome
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_cw[DATA_W-1:0];
                s1_syn_q  <= syn;
            end
        end
    end

    // Classify syndrome: clean, data-bit signature, lone check bit, else uncorrectable
    always_comb begin
        cls_d      = UNCORR;
        out_data_d = s1_data_q;
        out_pos_d  = '0;
        sig_hit    = 1'b0;
        if (s1_syn_q == '0) begin
            cls_d = CLEAN;
        end else begin
            for (int k = 0; k < DATA_W; k++) begin
                if (!sig_hit && (s1_syn_q == sig(4'(k)))) begin
                    sig_hit                 = 1'b1;
                    cls_d                   = CORR_DATA;
                    out_data_d[4'(k)]       = ~s1_data_q[4'(k)];
                    out_pos_d               = {1'b1, 4'(k)};
                end
            end
            if (!sig_hit && $onehot(s1_syn_q)) begin
                cls_d = CORR_CHK;
                for (int j = 0; j < CHK_W; j++) begin
                    if (s1_syn_q[4'(j)]) begin
                        out_pos_d = {1'b0, 4'(j)};
                    end
                end
            end
        end
        out_corr_d   = (cls_d == CORR_DATA) || (cls_d == CORR_CHK);
        out_uncorr_d = (cls_d == UNCORR);
    end

    // Stage 2: output registers, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_pos_q    <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= out_data_d;
                out_corr_q   <= out_corr_d;
                out_uncorr_q <= out_uncorr_d;
                out_pos_q    <= out_pos_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_corr    = out_corr_q;
    assign out_uncorr  = out_uncorr_q;
    assign out_err_pos = out_pos_q;

`ifdef ECC_DEC_STATS_EN
    logic [CNT_W-1:0] cnt_corr_q,   cnt_corr_d;
    logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

    // Saturating counters on the output handshake; clear has priority
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_corr_q && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (out_uncorr_q && (cnt_uncorr_q != '1)) begin
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule
